mont_result_unloader: RTL and testbench
=======================================

MONT_RESULT_UNLOADER -- requirements
Module: mont_result_unloader

Interface
REQ-001 The block SHALL take parameter INPUT_SIZE, default 2048, the operand/result width in bits.
REQ-002 The block SHALL take parameter WORD_SIZE, default 64, the bus word width in bits.
REQ-003 The block SHALL use derived constant NUM_WORDS = INPUT_SIZE/WORD_SIZE (32), the number of words per result.
REQ-004 clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset.
REQ-006 res_valid  input  1  Multiplier presents a finished result.
REQ-007 res_ready  output  1  Unloader can accept a result.
REQ-008 result  input  INPUT_SIZE  Montgomery product from the protected multiplier.
REQ-009 fault_flag  input  1  Fault-detection verdict, qualified by res_valid.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  Downstream accepts a word.
REQ-012 out_data  output  WORD_SIZE  Serialized result word, least-significant word first.
REQ-013 out_last  output  1  Final word of a frame.
REQ-014 out_fault  output  1  Current frame is a fault report, not data.
REQ-015 result_count  output  16  Frames delivered clean; saturates at 0xFFFF.
REQ-016 fault_count  output  16  Fault frames delivered; saturates at 0xFFFF.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, STREAM, FAULT.
REQ-018 res_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, on res_valid=1, the block SHALL capture result into a local buffer, clear the word index to 0, and go to STREAM if fault_flag=0 or to FAULT if fault_flag=1.
REQ-020 Latency: for a capture at edge N, out_valid SHALL be 1 in the cycle following edge N.
REQ-021 In STREAM, out_valid SHALL be 1 and out_data SHALL equal buffer word[idx] (bits idx*WORD_SIZE +: WORD_SIZE).
REQ-022 In STREAM, out_last SHALL be 1 exactly when idx = NUM_WORDS-1.
REQ-023 A word transfers only on out_valid && out_ready; idx SHALL increment only on a transfer.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last and out_fault SHALL hold their values unchanged.
REQ-025 On a transfer with out_last=1 in STREAM, the block SHALL increment result_count (saturating) and return to IDLE.
REQ-026 In FAULT, the block SHALL present one word: out_valid=1, out_data=0, out_fault=1, out_last=1.
REQ-027 On that transfer, the block SHALL increment fault_count (saturating) and return to IDLE.
REQ-028 The captured result of a faulty frame SHALL never appear on out_data.
REQ-029 In IDLE, out_valid, out_last and out_fault SHALL be 0 and out_data SHALL be 0.
REQ-030 Because res_ready=0 outside IDLE, there SHALL be at least one idle cycle between frames, giving a minimum of NUM_WORDS+1 cycles per clean result.
REQ-031 res_valid while res_ready=0 SHALL be ignored; the upstream holds it until accepted.
REQ-032 Counters at 0xFFFF SHALL stay at 0xFFFF when a further increment occurs.

Reset
REQ-033 When reset=0, the block SHALL go to IDLE asynchronously, including mid-frame, and the partial frame is discarded.
REQ-034 During reset, all outputs SHALL be 0, including res_ready, counters, buffer and idx.
REQ-035 res_ready SHALL become 1 at the first clock edge after reset deasserts.

Structure
REQ-036 INPUT_SIZE, WORD_SIZE, NUM_WORDS and the FSM state encoding SHALL live in a shared package also used by the multiplier top.
REQ-037 No sub-module is required; word selection SHALL use an indexed part-select of the buffer, not a 2048-bit shift.

Verification
REQ-038 Reset, then a result with word k = k+1 and fault_flag=0, out_ready=1 throughout -> 32 words 1..32 on consecutive cycles, out_last only on word 32, result_count=1.
REQ-039 Same result with out_ready toggling 1,0,0,1,... -> words stay stable while stalled, sequence 1..32 is intact, and there are no duplicates.
REQ-040 Result with all words 0xFFFF_FFFF_FFFF_FFFF and fault_flag=1 -> a single word 0 with out_fault=1 and out_last=1, fault_count=1, result_count unchanged.
REQ-041 Reset asserted after the 10th word transfer -> outputs 0 immediately; a following clean frame starts again at word 0.
REQ-042 Two back-to-back results with res_valid held high -> the second is accepted exactly one cycle after the first frame's last transfer.
REQ-043 Preload of result_count to 0xFFFE (force), then 2 clean frames -> result_count=0xFFFF and holds.

Source files
------------

// File: rtl/mont_result_unloader_pkg.sv
// -----------------------------------------------------------------------------
// mont_result_unloader_pkg
//
// Shared definitions for the Montgomery multiplier result path. The multiplier
// top and the result unloader both import this package so that operand width,
// bus word width and the unloader FSM encoding have a single definition.
//
// Contents:
//   INPUT_SIZE  - operand / result width in bits
//   WORD_SIZE   - output bus word width in bits
//   NUM_WORDS   - words per result (INPUT_SIZE / WORD_SIZE)
//   CNT_W       - width of the delivered-frame statistics counters
//   state_t     - unloader FSM state encoding
//   idx_width() - width of a counter able to index n words (at least 1 bit)
// -----------------------------------------------------------------------------
package mont_result_unloader_pkg;

    localparam int INPUT_SIZE = 2048;
    localparam int WORD_SIZE  = 64;
    localparam int NUM_WORDS  = INPUT_SIZE / WORD_SIZE;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mont_result_unloader.sv
// -----------------------------------------------------------------------------
// mont_result_unloader
//
// Takes one finished Montgomery product from the protected multiplier and
// serialises it onto a ready/valid word bus, least-significant word first.
// If the multiplier's fault detector flagged the result, the product is
// withheld and a single zero word marked out_fault/out_last is sent instead.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   res_valid    in   multiplier presents a finished result
//   res_ready    out  unloader can accept a result (only while idle)
//   result       in   INPUT_SIZE-bit Montgomery product
//   fault_flag   in   fault verdict, qualified by res_valid
//   out_valid    out  out_data holds a valid word
//   out_ready    in   downstream accepts the word
//   out_data     out  WORD_SIZE-bit serialised result word
//   out_last     out  final word of the frame
//   out_fault    out  current frame is a fault report
//   result_count out  clean frames delivered, saturating
//   fault_count  out  fault frames delivered, saturating
// -----------------------------------------------------------------------------
module mont_result_unloader #(
    parameter int INPUT_SIZE = mont_result_unloader_pkg::INPUT_SIZE,
    parameter int WORD_SIZE  = mont_result_unloader_pkg::WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [INPUT_SIZE-1:0] result,
    input  logic                  fault_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic                  out_last,
    output logic                  out_fault,
    output logic [15:0]           result_count,
    output logic [15:0]           fault_count
);

    import mont_result_unloader_pkg::*;

    localparam int NUM_WORDS = INPUT_SIZE / WORD_SIZE;
    localparam int IDX_W     = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t                 state;
    logic [INPUT_SIZE-1:0]  buffer;
    logic [IDX_W-1:0]       idx;

    logic [IDX_W-1:0]       idx_next;
    logic [WORD_SIZE-1:0]   next_word;
    logic                   xfer;

    assign idx_next = idx + 1'b1;
    assign xfer     = out_valid && out_ready;

    // Outputs are registered, so the word that follows a transfer is selected
    // one index ahead. Indexed part-select keeps this a word mux rather than a
    // full-width shifter.
    assign next_word = buffer[int'(idx_next) * WORD_SIZE +: WORD_SIZE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            buffer       <= '0;
            idx          <= '0;
            res_ready    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_fault    <= 1'b0;
            result_count <= '0;
            fault_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // res_ready comes up on the first edge after reset, so a
                    // result is only ever taken against a visible res_ready.
                    res_ready <= 1'b1;
                    if (res_valid && res_ready) begin
                        buffer    <= result;
                        idx       <= '0;
                        res_ready <= 1'b0;
                        out_valid <= 1'b1;
                        if (fault_flag) begin
                            state     <= ST_FAULT;
                            out_data  <= '0;
                            out_last  <= 1'b1;
                            out_fault <= 1'b1;
                        end else begin
                            state     <= ST_STREAM;
                            out_data  <= result[WORD_SIZE-1:0];
                            out_last  <= (NUM_WORDS == 1);
                            out_fault <= 1'b0;
                        end
                    end
                end

                ST_STREAM: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            state        <= ST_IDLE;
                            res_ready    <= 1'b1;
                            out_valid    <= 1'b0;
                            out_data     <= '0;
                            out_last     <= 1'b0;
                            out_fault    <= 1'b0;
                            result_count <= sat_inc(result_count);
                        end else begin
                            idx      <= idx_next;
                            out_data <= next_word;
                            out_last <= (idx_next == LAST_IDX);
                        end
                    end
                end

                ST_FAULT: begin
                    // Single zero word; the captured product never reaches
                    // out_data for a faulty frame.
                    if (xfer) begin
                        state       <= ST_IDLE;
                        res_ready   <= 1'b1;
                        out_valid   <= 1'b0;
                        out_data    <= '0;
                        out_last    <= 1'b0;
                        out_fault   <= 1'b0;
                        fault_count <= sat_inc(fault_count);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    res_ready <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                    out_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_result_unloader.sv
module tb_mont_result_unloader;

    import mont_result_unloader_pkg::*;

    localparam int IN = INPUT_SIZE;
    localparam int W  = WORD_SIZE;
    localparam int NW = NUM_WORDS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [IN-1:0] result = '0;
    logic          fault_flag = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_fault;
    logic [15:0]   result_count;
    logic [15:0]   fault_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: delivered-frame counters
    logic [15:0] exp_rc = '0;
    logic [15:0] exp_fc = '0;

    mont_result_unloader #(
        .INPUT_SIZE(IN),
        .WORD_SIZE (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .fault_flag  (fault_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_fault   (out_fault),
        .result_count(result_count),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [IN-1:0] seq_result();
        logic [IN-1:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) r[k*W +: W] = 64'(k + 1);
        return r;
    endfunction

    function automatic logic [IN-1:0] rand_result();
        logic [IN-1:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) r[k*W +: W] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic bump_rc();
        if (exp_rc < 16'hFFFF) exp_rc = exp_rc + 16'd1;
    endtask

    task automatic bump_fc();
        if (exp_fc < 16'hFFFF) exp_fc = exp_fc + 16'd1;
    endtask

    // Present a result and wait (bounded) until it is taken; returns at
    // posedge+1 just after the capture edge.
    task automatic accept(input logic [IN-1:0] r, input logic f, input bit hold);
        bit got;
        res_valid  = 1'b1;
        result     = r;
        fault_flag = f;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (res_ready === 1'b1) got = 1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept res_ready=%b required=1 within 50 cycles", res_ready);
        end
        if (!hold) begin
            res_valid  = 1'b0;
            fault_flag = 1'b0;
        end
    endtask

    // Consume words of frame r, checking every cycle against the expected
    // word list. mode 0: ready always, 1: ready 1,0,0 repeating, 2: random.
    // Stops after stop_after transfers (negative = whole frame).
    task automatic stream_words(input logic [IN-1:0] r, input logic f,
                                input int mode, input int stop_after);
        int len, pos, cyc;
        bit prev_stall;
        logic [W-1:0] prev_data, exp_d;
        len = f ? 1 : NW;
        pos = 0;
        cyc = 0;
        prev_stall = 0;
        prev_data = '0;
        while (pos < len && pos != stop_after && cyc < 20 * NW) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            exp_d = f ? '0 : r[pos*W +: W];
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (pos == len - 1) ||
                out_fault !== f || res_ready !== 1'b0) begin
                failures++;
                $display("FAIL stream_word[%0d] valid=%b data=%h last=%b fault=%b res_ready=%b required valid=1 data=%h last=%b fault=%b res_ready=0",
                         pos, out_valid, out_data, out_last, out_fault, res_ready,
                         exp_d, (pos == len - 1), f);
            end
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold[%0d] data=%h required=%h", pos, out_data, prev_data);
                end
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            if (out_ready) pos++;
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (pos < len && pos != stop_after) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout transferred=%0d required=%0d", pos, len);
        end
    endtask

    // One idle cycle: outputs quiet, res_ready high, counters as modelled.
    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            out_fault !== 1'b0 || res_ready !== 1'b1 ||
            result_count !== exp_rc || fault_count !== exp_fc) begin
            failures++;
            $display("FAIL %s valid=%b data=%h last=%b fault=%b res_ready=%b rc=%h fc=%h required 0/0/0/0/1 rc=%h fc=%h",
                     name, out_valid, out_data, out_last, out_fault, res_ready,
                     result_count, fault_count, exp_rc, exp_fc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            out_fault !== 1'b0 || result_count !== 16'h0 || fault_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs res_ready=%b valid=%b data=%h rc=%h fc=%h required all 0",
                     res_ready, out_valid, out_data, result_count, fault_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge res_ready=%b required=0", res_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge res_ready=%b required=1", res_ready);
        end
    endtask

    task automatic test_basic();
        logic [IN-1:0] r;
        r = seq_result();
        accept(r, 1'b0, 1'b0);
        stream_words(r, 1'b0, 0, -1);
        bump_rc();
        check_idle("basic_idle");
    endtask

    task automatic test_stall();
        logic [IN-1:0] r;
        r = seq_result();
        accept(r, 1'b0, 1'b0);
        stream_words(r, 1'b0, 1, -1);
        bump_rc();
        check_idle("stall_idle");
    endtask

    task automatic test_fault();
        logic [IN-1:0] r;
        r = '1;
        accept(r, 1'b1, 1'b0);
        stream_words(r, 1'b1, 0, -1);
        bump_fc();
        check_idle("fault_idle");
    endtask

    task automatic test_random();
        logic [IN-1:0] r;
        logic f;
        for (int n = 0; n < 6; n++) begin
            r = rand_result();
            f = ($urandom_range(0, 3) == 0);
            accept(r, f, 1'b0);
            stream_words(r, f, 2, -1);
            if (f) bump_fc();
            else bump_rc();
            check_idle("random_idle");
        end
    endtask

    task automatic test_reset_midframe();
        logic [IN-1:0] r;
        r = seq_result();
        accept(r, 1'b0, 1'b0);
        stream_words(r, 1'b0, 0, 10);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (res_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            out_fault !== 1'b0 || result_count !== 16'h0 || fault_count !== 16'h0) begin
            failures++;
            $display("FAIL midframe_reset res_ready=%b valid=%b data=%h rc=%h fc=%h required all 0",
                     res_ready, out_valid, out_data, result_count, fault_count);
        end
        exp_rc = '0;
        exp_fc = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        r = rand_result();
        accept(r, 1'b0, 1'b0);
        stream_words(r, 1'b0, 0, -1);
        bump_rc();
        check_idle("after_reset_idle");
    endtask

    task automatic test_back_to_back();
        logic [IN-1:0] r1, r2;
        r1 = rand_result();
        r2 = seq_result();
        accept(r1, 1'b0, 1'b1);
        stream_words(r1, 1'b0, 0, -1);
        result = r2;
        bump_rc();
        check_idle("b2b_gap");
        res_valid = 1'b0;
        stream_words(r2, 1'b0, 0, -1);
        bump_rc();
        check_idle("b2b_idle");
    endtask

    task automatic test_saturation();
        logic [IN-1:0] r;
        @(negedge clk);
        force dut.result_count = 16'hFFFE;
        #1;
        release dut.result_count;
        exp_rc = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            r = rand_result();
            @(posedge clk);
            #1;
            accept(r, 1'b0, 1'b0);
            stream_words(r, 1'b0, 2, -1);
            bump_rc();
            check_idle("saturation_idle");
        end
        checks++;
        if (result_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL saturation_hold rc=%h required=ffff", result_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_fault();
        test_random();
        test_reset_midframe();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
